argmin_tree: RTL

ARGMIN_TREE -- requirements
Module: argmin_tree

---
 rtl/argmin_tree_pkg.sv | 47 ++++
 rtl/argmin_node.sv | 38 +++
 rtl/argmin_tree.sv | 124 ++++++++++++
 3 files changed

// File: rtl/argmin_tree_pkg.sv
// Shared payload type and tree-sizing helpers for argmin_tree.
// Payload fields are sized to the widest supported lane; narrower configurations extend into them.
package argmin_tree_pkg;

   localparam int MAX_DW = 32;
   localparam int MAX_PW = 32;
   localparam int MAX_IW = 16;
   localparam int MAG_W  = MAX_DW + 1;

   typedef struct packed {
      logic [MAG_W-1:0]         mag;
      logic signed [MAX_DW-1:0] err;
      logic signed [MAX_PW-1:0] pos;
      logic [MAX_IW-1:0]        idx;
   } node_t;

   // All-ones magnitude exceeds any real |error|, so padding never wins.
   localparam node_t NODE_PAD = '{mag: '1, err: '0, pos: '0, idx: '1};

   function automatic int ceil_log(input int n, input int radix);
      int     l;
      longint p;
      l = 0;
      p = 1;
      for (int i = 0; i < 64; i++) begin
         if (p < longint'(n)) begin
            p = p * longint'(radix);
            l++;
         end
      end
      return l;
   endfunction

   function automatic int calc_levels(input int n_in, input int n_in_one);
      return ceil_log(n_in, n_in_one);
   endfunction

   function automatic int level_width(input int n, input int radix, input int lvl);
      int w;
      w = n;
      for (int i = 0; i < lvl; i++) begin
         w = (w + radix - 1) / radix;
      end
      return w;
   endfunction

endpackage

// File: rtl/argmin_node.sv
// One tree node: lowest-index minimum-magnitude pick over N_IN_ONE candidates, one register stage.
// Output register holds while i_en is low.
module argmin_node
   import argmin_tree_pkg::*;
#(
   parameter int N_IN_ONE = 4
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  i_en,
   input  node_t i_cand [N_IN_ONE],
   output node_t o_win
);

   node_t w_best;
   node_t r_win;

   // Strict less-than keeps the earlier (lower-index) candidate on ties.
   always_comb begin
      w_best = i_cand[0];
      for (int k = 1; k < N_IN_ONE; k++) begin
         if (i_cand[k].mag < w_best.mag) begin
            w_best = i_cand[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_win <= '0;
      end else if (i_en) begin
         r_win <= w_best;
      end
   end

   assign o_win = r_win;

endmodule

// File: rtl/argmin_tree.sv
// Pipelined argmin of |error| over N_IN lanes, radix N_IN_ONE; LEVELS register stages, one beat/cycle.
// Whole pipe stalls while m_valid && !m_ready (s_ready low); ARGMIN_TREE_HIT_CNT_EN adds hit_cnt.
module argmin_tree
   import argmin_tree_pkg::*;
#(
   parameter int N_IN       = 16,
   parameter int N_IN_ONE   = 4,
   parameter int DATA_WIDTH = 16,
   parameter int POS_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic signed [DATA_WIDTH-1:0] s_error [N_IN],
   input  logic signed [POS_WIDTH-1:0]  s_pos [N_IN],
   input  logic [DATA_WIDTH:0]          s_thresh,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic signed [DATA_WIDTH-1:0] m_error,
   output logic signed [POS_WIDTH-1:0]  m_pos,
   output logic [$clog2(N_IN)-1:0]      m_idx,
   output logic                         m_hit
`ifdef ARGMIN_TREE_HIT_CNT_EN
   ,
   output logic [31:0]                  hit_cnt,
   input  logic                         hit_cnt_clr
`endif
);

   localparam int LEVELS = calc_levels(N_IN, N_IN_ONE);
   localparam int IDX_W  = $clog2(N_IN);

   logic                r_vld [LEVELS];
   logic [DATA_WIDTH:0] r_thr [LEVELS];
   node_t               w_stage [LEVELS+1][N_IN];
   node_t               w_res;
   logic                w_en;
   logic                w_unused;

   assign w_en    = !m_valid || m_ready;
   assign s_ready = w_en;

   // Magnitude in DATA_WIDTH+1 bits so the most negative error does not wrap.
   for (genvar k = 0; k < N_IN; k++) begin : g_lane
      logic signed [DATA_WIDTH:0] w_ext;
      logic signed [DATA_WIDTH:0] w_neg;
      logic [DATA_WIDTH:0]        w_mag;
      assign w_ext = {s_error[k][DATA_WIDTH-1], s_error[k]};
      assign w_neg = -w_ext;
      assign w_mag = w_ext[DATA_WIDTH] ? w_neg : w_ext;
      assign w_stage[0][k] = '{mag: MAG_W'(w_mag),
                               err: MAX_DW'(s_error[k]),
                               pos: MAX_PW'(s_pos[k]),
                               idx: MAX_IW'(k)};
   end

   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int W_IN  = level_width(N_IN, N_IN_ONE, l);
      localparam int W_OUT = level_width(N_IN, N_IN_ONE, l + 1);
      for (genvar g = 0; g < W_OUT; g++) begin : g_grp
         node_t w_cand [N_IN_ONE];
         for (genvar c = 0; c < N_IN_ONE; c++) begin : g_cand
            if (g * N_IN_ONE + c < W_IN) begin : g_real
               assign w_cand[c] = w_stage[l][g*N_IN_ONE+c];
            end else begin : g_pad
               assign w_cand[c] = NODE_PAD;
            end
         end
         argmin_node #(
            .N_IN_ONE (N_IN_ONE)
         ) u_node (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_en),
            .i_cand (w_cand),
            .o_win  (w_stage[l+1][g])
         );
      end
      for (genvar g = W_OUT; g < N_IN; g++) begin : g_fill
         assign w_stage[l+1][g] = NODE_PAD;
      end
   end

   // Valid and threshold ride alongside the payload so each beat is judged on its own threshold.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int l = 0; l < LEVELS; l++) begin
            r_vld[l] <= 1'b0;
            r_thr[l] <= '0;
         end
      end else if (w_en) begin
         r_vld[0] <= s_valid;
         r_thr[0] <= s_thresh;
         for (int l = 1; l < LEVELS; l++) begin
            r_vld[l] <= r_vld[l-1];
            r_thr[l] <= r_thr[l-1];
         end
      end
   end

   assign w_res    = w_stage[LEVELS][0];
   assign m_valid  = r_vld[LEVELS-1];
   assign m_error  = w_res.err[DATA_WIDTH-1:0];
   assign m_pos    = w_res.pos[POS_WIDTH-1:0];
   assign m_idx    = w_res.idx[IDX_W-1:0];
   assign m_hit    = r_vld[LEVELS-1] && (w_res.mag[DATA_WIDTH:0] <= r_thr[LEVELS-1]);
   assign w_unused = ^w_res;

`ifdef ARGMIN_TREE_HIT_CNT_EN
   logic [31:0] r_hit_cnt;

   always_ff @(posedge clk) begin
      if (rst || hit_cnt_clr) begin
         r_hit_cnt <= '0;
      end else if (m_valid && m_ready && m_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
         r_hit_cnt <= r_hit_cnt + 32'd1;
      end
   end

   assign hit_cnt = r_hit_cnt;
`endif

endmodule
